// File: rtl/disp_pkg.sv
// Shared constants for the multiplexed display blocks: default geometry,
// refresh rate and the active-low anode convention.
package disp_pkg;

  localparam int NUM_DIGITS_DEF  = 4;
  localparam int DIGIT_W_DEF     = 4;
  localparam int REFRESH_DIV_DEF = 100000;

  // Anodes are active-low, so a dark digit drives its enable bit high.
  localparam logic ANODE_OFF = 1'b1;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/digit_scan_mux_scan_tick_gen.sv
// Refresh prescaler: counts 0..REFRESH_DIV-1 while enabled and flags the last
// count so the scanner can advance to the next digit.
module scan_tick_gen
  import disp_pkg::*;
#(
  parameter int REFRESH_DIV = REFRESH_DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int              PW   = cnt_width(REFRESH_DIV);
  localparam logic [PW-1:0]   LAST = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] prescaler;

  // With REFRESH_DIV=1 the counter is pinned at zero and every enabled cycle ticks.
  assign tick = en && (prescaler == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler <= '0;
    end else if (tick) begin
      prescaler <= '0;
    end else if (en) begin
      prescaler <= prescaler + 1'b1;
    end
  end

endmodule

// File: rtl/digit_scan_mux.sv
// Time-multiplexed digit scanner for multi-digit 7-segment displays.
// Optional leading-zero blanking is compiled in with `define LEADING_ZERO_BLANK_EN.
module digit_scan_mux
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS  = NUM_DIGITS_DEF,
  parameter int DIGIT_W     = DIGIT_W_DEF,
  parameter int REFRESH_DIV = REFRESH_DIV_DEF
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            en,
  input  logic [NUM_DIGITS*DIGIT_W-1:0]   digits_in,
  input  logic [NUM_DIGITS-1:0]           blank_mask,
  output logic [DIGIT_W-1:0]              out_digit,
  output logic [NUM_DIGITS-1:0]           anode,
  output logic [$clog2(NUM_DIGITS)-1:0]   digit_idx,
  output logic                            frame_done
);

  localparam int             IW       = $clog2(NUM_DIGITS);
  localparam logic [IW-1:0]  IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [IW-1:0]                  idx;
  logic [NUM_DIGITS*DIGIT_W-1:0]  snapshot;
  logic                           pending;
  logic                           tick;
  logic                           last_idx;
  logic                           wrap;
  logic                           lz_blank;
  logic                           dark;
  logic [DIGIT_W-1:0]             sel_digit;

  scan_tick_gen #(
    .REFRESH_DIV (REFRESH_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .tick  (tick)
  );

  assign last_idx  = (idx == IDX_LAST);
  assign wrap      = tick && last_idx;
  assign sel_digit = snapshot[int'(idx)*DIGIT_W +: DIGIT_W];

`ifdef LEADING_ZERO_BLANK_EN
  // Walk down from the most significant digit; a digit is a leading zero while
  // it and everything above it is zero. Digit 0 is never considered.
  logic tail_zero;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    lz_blank  = 1'b0;
    tail_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      tail_zero = tail_zero && (snapshot[k*DIGIT_W +: DIGIT_W] == '0);
      if (idx == IW'(k)) begin
        lz_blank = tail_zero;
      end
    end
  end
`else
  assign lz_blank = 1'b0;
`endif

  assign dark = !en || blank_mask[idx] || lz_blank;

  always_ff @(posedge clk) begin
    if (reset) begin
      idx        <= '0;
      snapshot   <= '0;
      pending    <= 1'b1;
      out_digit  <= '0;
      anode      <= {NUM_DIGITS{ANODE_OFF}};
      digit_idx  <= '0;
      frame_done <= 1'b0;
    end else begin
      // Snapshot only at frame boundaries (plus once after reset) so digits never tear.
      if (pending || wrap) begin
        snapshot <= digits_in;
      end
      pending <= 1'b0;

      if (tick) begin
        idx <= last_idx ? '0 : idx + 1'b1;
      end

      frame_done <= wrap;
      digit_idx  <= idx;
      out_digit  <= sel_digit;
      anode      <= dark ? {NUM_DIGITS{ANODE_OFF}} : ~(NUM_DIGITS'(1) << idx);
    end
  end

endmodule
